// File: rtl/counter_timer_sched.sv
// Round-robin scheduler that time-shares one binary up-counter/match datapath
// among NUM_REQ one-shot timeout requesters. Optional warn pulses: CNT_SCHED_WARN_EN.
module counter_timer_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned WARN_TICKS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt_q,
  output logic [NUM_REQ-1:0]       warn
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]    PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [PS_W-1:0]      presc_q, presc_d;
  logic [CNT_W-1:0]     target_q, target_d;
  logic [CNT_W-1:0]     cnt_d;
  logic [NUM_REQ-1:0]   grant_d, done_d;
  logic                 busy_d;

  logic                 pick_valid, hi_valid;
  logic [IDX_W-1:0]     pick_idx, hi_idx, lo_idx;
  logic [CNT_W-1:0]     pick_count;
  logic [NUM_REQ-1:0]   pick_oh, owner_oh;
  logic                 tick;

  // Round-robin pick: lowest requester at or above rr_q, else lowest overall.
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= rr_q) begin
          hi_valid = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    pick_valid = |req;
    pick_idx   = hi_valid ? hi_idx : lo_idx;
  end

  assign pick_count = req_count[32'(pick_idx)*CNT_W +: CNT_W];
  assign pick_oh    = NUM_REQ'(1) << pick_idx;
  assign owner_oh   = NUM_REQ'(1) << owner_q;
  assign tick       = (presc_q == PS_LAST);

`ifdef CNT_SCHED_WARN_EN
  localparam int unsigned   CW1      = CNT_W + 1;
  localparam logic [CW1-1:0] WARN_LIM = CW1'(WARN_TICKS);
  logic [NUM_REQ-1:0] warn_d;
  logic [CNT_W-1:0]   warn_at;
  assign warn_at = target_q - CNT_W'(1) - CNT_W'(WARN_TICKS);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    presc_d  = presc_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    grant_d  = '0;
    done_d   = '0;
    busy_d   = 1'b0;
`ifdef CNT_SCHED_WARN_EN
    warn_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d  = RUN;
          owner_d  = pick_idx;
          rr_d     = (pick_idx == IDX_LAST) ? '0 : pick_idx + IDX_W'(1);
          presc_d  = '0;
          target_d = (pick_count == '0) ? CNT_W'(1) : pick_count;
          grant_d  = pick_oh;
        end
      end
      RUN: begin
        // A dropped request aborts, even on the terminal tick.
        if (!req[owner_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
          presc_d = '0;
        end else begin
          grant_d = owner_oh;
          if (tick) begin
            presc_d = '0;
            if (cnt_q == target_q - CNT_W'(1)) begin
              state_d = DONE;
              grant_d = '0;
              done_d  = owner_oh;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            presc_d = presc_q + PS_W'(1);
          end
`ifdef CNT_SCHED_WARN_EN
          if (tick && ({1'b0, target_q} > WARN_LIM) && (cnt_q == warn_at))
            warn_d = owner_oh;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      presc_q  <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      presc_q  <= presc_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      grant    <= grant_d;
      done     <= done_d;
      busy     <= busy_d;
    end
  end

`ifdef CNT_SCHED_WARN_EN
  always_ff @(posedge clk) begin
    if (reset) warn <= '0;
    else       warn <= warn_d;
  end
`else
  assign warn = '0;
`endif

endmodule
